// File: rtl/overlap_accum_seq_if.sv
// Bundle carrying the partial-product input and the result output of overlap_accum_seq.
// Pure wiring. It adds no latency.
// Valid/ready on both channels. The consumer side uses the slave modport.
interface overlap_accum_seq_if #(
    parameter int SEG_W = 33,
    parameter int NSEG  = 3
);
    localparam int PP_W  = 2*SEG_W - 1;
    localparam int OUT_W = (NSEG-1)*SEG_W + PP_W;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    logic             pp_valid;
    logic             pp_ready;
    logic [IDX_W-1:0] pp_idx;
    logic [PP_W-1:0]  pp_data;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;

    // producer of partial products / consumer of results
    modport master (
        output pp_valid, pp_idx, pp_data, res_ready,
        input  pp_ready, res_valid, res_data
    );

    // the accumulator itself
    modport slave (
        input  pp_valid, pp_idx, pp_data, res_ready,
        output pp_ready, res_valid, res_data
    );
endinterface

// File: rtl/overlap_accum_seq.sv
// Overlap-adds NSEG carry-less partial products at k*SEG_W offsets (GF(2) XOR) into one result frame.
// res_valid rises 1 cycle after the accept that completes the frame.
// pp_ready is held while a result waits; it bypasses res_ready so there is no bubble. Optional OVERLAP_ACCUM_DUPCHK_EN adds err.
module overlap_accum_seq #(
    parameter int SEG_W = 33,
    parameter int NSEG  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    overlap_accum_seq_if.slave bus
`ifdef OVERLAP_ACCUM_DUPCHK_EN
    ,
    output logic               err
`endif
);
    localparam int PP_W  = 2*SEG_W - 1;
    localparam int OUT_W = (NSEG-1)*SEG_W + PP_W;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int CNT_W = $clog2(NSEG + 1);

    // A single partial product cannot define frame completion.
    generate
        if (NSEG < 2) begin : g_bad_nseg
            $error("overlap_accum_seq: NSEG must be >= 2");
        end
    endgenerate

    typedef enum logic {ACC, DONE} state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   shifted;
    logic               in_range;
    logic               accept;

    // Place the incoming product at its segment offset. Out-of-range indices contribute nothing.
    always_comb begin
        shifted  = '0;
        in_range = (32'(bus.pp_idx) < NSEG);
        for (int k = 0; k < NSEG; k++) begin
            if (bus.pp_idx == IDX_W'(k))
                shifted = OUT_W'(bus.pp_data) << (k*SEG_W);
        end
    end

    // Ready is always high while collecting. When a result is held, ready follows res_ready.
    always_comb begin
        bus.pp_ready = rst_n && !flush && ((state_q == ACC) || bus.res_ready);
    end

    assign accept        = bus.pp_valid && bus.pp_ready;
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_data  = acc_q;

    // Next state. The handshake in DONE may start the next frame in the same cycle. flush overrides everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = acc_q ^ shifted;
                    cnt_d = cnt_q + CNT_W'(in_range);
                    if (cnt_d == CNT_W'(NSEG))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = ACC;
                    acc_d   = accept ? shifted : '0;
                    cnt_d   = accept ? CNT_W'(in_range) : '0;
                end
            end
            default: state_d = ACC;
        endcase
        if (flush) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    // State and accumulator registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef OVERLAP_ACCUM_DUPCHK_EN
    logic [NSEG-1:0] seen_q, seen_d, idx_onehot;
    logic            err_q, err_d;

    // One-hot form of the incoming index. It is all-zero when the index is out of range.
    always_comb begin
        idx_onehot = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (bus.pp_idx == IDX_W'(k))
                idx_onehot[k] = 1'b1;
        end
    end

    // Seen-mask tracking. err stays set across frames and is cleared only by flush or reset.
    always_comb begin
        seen_d = seen_q;
        err_d  = err_q;
        case (state_q)
            ACC: begin
                if (accept) begin
                    if (((seen_q & idx_onehot) != '0) || !in_range)
                        err_d = 1'b1;
                    seen_d = seen_q | idx_onehot;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    seen_d = accept ? idx_onehot : '0;
                    if (accept && !in_range)
                        err_d = 1'b1;
                end
            end
            default: seen_d = '0;
        endcase
        if (flush) begin
            seen_d = '0;
            err_d  = 1'b0;
        end
    end

    // Duplicate-check registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
            err_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_overlap_accum_seq.sv
// Directed bench for overlap_accum_seq at default parameters.
// It checks outputs 1 time unit after each rising edge and drives inputs at the same point.
// It runs the optional duplicate-check tests when OVERLAP_ACCUM_DUPCHK_EN is defined.
module tb_overlap_accum_seq;
    localparam int SEG_W = 33;
    localparam int NSEG  = 3;
    localparam int PP_W  = 2*SEG_W - 1;
    localparam int OUT_W = (NSEG-1)*SEG_W + PP_W;

    logic clk;
    logic rst_n;
    logic flush;
`ifdef OVERLAP_ACCUM_DUPCHK_EN
    logic err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    overlap_accum_seq_if #(.SEG_W(SEG_W), .NSEG(NSEG)) bus ();

    overlap_accum_seq #(.SEG_W(SEG_W), .NSEG(NSEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef OVERLAP_ACCUM_DUPCHK_EN
        ,
        .err   (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] idx, input logic [PP_W-1:0] data);
        bus.pp_valid = 1'b1;
        bus.pp_idx   = idx;
        bus.pp_data  = data;
        step();
        bus.pp_valid = 1'b0;
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
    endtask

    function automatic logic [OUT_W-1:0] place(input logic [PP_W-1:0] d, input int k);
        return OUT_W'(d) << (k*SEG_W);
    endfunction

    function automatic logic [PP_W-1:0] rnd();
        return {1'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        logic [OUT_W-1:0] exp;
        logic [PP_W-1:0]  a, b, c, d;
        logic [PP_W-1:0]  ones65;

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.pp_valid  = 1'b0;
        bus.pp_idx    = '0;
        bus.pp_data   = '0;
        bus.res_ready = 1'b0;

        // reset state
        #3;
        check("rst_res_valid", OUT_W'(bus.res_valid), '0);
        check("rst_res_data", bus.res_data, '0);
        check("rst_pp_ready", OUT_W'(bus.pp_ready), '0);
        step();
        step();
        #3 rst_n = 1'b1;
        step();
        check("post_rst_pp_ready", OUT_W'(bus.pp_ready), OUT_W'(1));
        check("post_rst_res_valid", OUT_W'(bus.res_valid), '0);
`ifdef OVERLAP_ACCUM_DUPCHK_EN
        check("rst_err", OUT_W'(err), '0);
`endif

        // single bits at each segment offset
        send(2'd0, PP_W'(1));
        send(2'd1, PP_W'(1));
        check("t1_not_done", OUT_W'(bus.res_valid), '0);
        send(2'd2, PP_W'(1));
        exp = '0; exp[0] = 1'b1; exp[33] = 1'b1; exp[66] = 1'b1;
        check("t1_valid", OUT_W'(bus.res_valid), OUT_W'(1));
        check("t1_data", bus.res_data, exp);
        consume();
        check("t1_consumed_valid", OUT_W'(bus.res_valid), '0);
        check("t1_consumed_data", bus.res_data, '0);

        // overlapping all-ones products cancel in the overlap region
        ones65 = 65'h1_FFFF_FFFF_FFFF_FFFF;
        send(2'd0, ones65);
        send(2'd1, ones65);
        send(2'd2, '0);
        exp = '0;
        for (int i = 0;  i <= 32; i++) exp[i] = 1'b1;
        for (int i = 65; i <= 97; i++) exp[i] = 1'b1;
        check("t2_data", bus.res_data, exp);
        consume();

        // index order does not matter
        a = rnd(); b = rnd(); c = rnd();
        exp = place(a, 0) ^ place(b, 1) ^ place(c, 2);
        send(2'd2, c);
        send(2'd0, a);
        send(2'd1, b);
        check("t3_order201", bus.res_data, exp);
        consume();
        send(2'd0, a);
        send(2'd1, b);
        send(2'd2, c);
        check("t3_order012", bus.res_data, exp);
        consume();

        // out-of-range index ignored; duplicate index XORed and counted
        a = rnd(); b = rnd(); c = rnd(); d = rnd();
        send(2'd0, a);
        send(2'd3, b);
        check("t4_oor_data", bus.res_data, place(a, 0));
        check("t4_oor_valid", OUT_W'(bus.res_valid), '0);
        send(2'd0, c);
        check("t4_dup_valid", OUT_W'(bus.res_valid), '0);
        check("t4_dup_data", bus.res_data, place(a ^ c, 0));
        send(2'd1, d);
        check("t4_done_valid", OUT_W'(bus.res_valid), OUT_W'(1));
        check("t4_done_data", bus.res_data, place(a ^ c, 0) ^ place(d, 1));
        consume();

        // backpressure in DONE, then handshake with a simultaneous accept
        a = rnd(); b = rnd(); c = rnd();
        exp = place(a, 0) ^ place(b, 1) ^ place(c, 2);
        send(2'd0, a);
        send(2'd1, b);
        send(2'd2, c);
        bus.pp_valid = 1'b1;
        bus.pp_idx   = 2'd0;
        bus.pp_data  = PP_W'(5);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_pp_ready", OUT_W'(bus.pp_ready), '0);
            check("t5_hold_data", bus.res_data, exp);
            check("t5_hold_valid", OUT_W'(bus.res_valid), OUT_W'(1));
            step();
        end
        bus.res_ready = 1'b1;
        #1;
        check("t5_bypass_pp_ready", OUT_W'(bus.pp_ready), OUT_W'(1));
        step();
        bus.res_ready = 1'b0;
        bus.pp_valid  = 1'b0;
        check("t5_next_valid", OUT_W'(bus.res_valid), '0);
        check("t5_next_acc", bus.res_data, OUT_W'(5));
        a = rnd(); b = rnd();
        send(2'd1, a);
        check("t5_cnt_valid", OUT_W'(bus.res_valid), '0);
        send(2'd2, b);
        check("t5_frame_valid", OUT_W'(bus.res_valid), OUT_W'(1));
        check("t5_frame_data", bus.res_data, OUT_W'(5) ^ place(a, 1) ^ place(b, 2));
        consume();

        // flush mid-frame discards partial sums
        a = rnd(); b = rnd(); c = rnd();
        send(2'd0, a);
        send(2'd1, b);
        flush        = 1'b1;
        bus.pp_valid = 1'b1;
        bus.pp_idx   = 2'd2;
        bus.pp_data  = c;
        #1;
        check("t6_flush_pp_ready", OUT_W'(bus.pp_ready), '0);
        step();
        flush        = 1'b0;
        bus.pp_valid = 1'b0;
        check("t6_flush_data", bus.res_data, '0);
        check("t6_flush_valid", OUT_W'(bus.res_valid), '0);
        a = rnd(); b = rnd(); c = rnd();
        send(2'd1, b);
        send(2'd2, c);
        send(2'd0, a);
        check("t6_fresh_data", bus.res_data, place(a, 0) ^ place(b, 1) ^ place(c, 2));
        // flush wins over the result handshake in DONE
        flush         = 1'b1;
        bus.res_ready = 1'b1;
        step();
        flush         = 1'b0;
        bus.res_ready = 1'b0;
        check("t6_flush_done_valid", OUT_W'(bus.res_valid), '0);
        check("t6_flush_done_data", bus.res_data, '0);

        // asynchronous reset between edges in the middle of a frame
        a = rnd(); b = rnd();
        send(2'd0, a);
        send(2'd1, b);
        #2 rst_n = 1'b0;
        #1;
        check("t7_arst_data", bus.res_data, '0);
        check("t7_arst_valid", OUT_W'(bus.res_valid), '0);
        check("t7_arst_pp_ready", OUT_W'(bus.pp_ready), '0);
        #3 rst_n = 1'b1;
        step();
        a = rnd(); b = rnd(); c = rnd();
        send(2'd0, a);
        send(2'd1, b);
        check("t7_after_not_done", OUT_W'(bus.res_valid), '0);
        send(2'd2, c);
        check("t7_after_valid", OUT_W'(bus.res_valid), OUT_W'(1));
        check("t7_after_data", bus.res_data, place(a, 0) ^ place(b, 1) ^ place(c, 2));
        consume();

`ifdef OVERLAP_ACCUM_DUPCHK_EN
        // duplicate index raises a sticky err that only flush clears
        check("t8_err_clear", OUT_W'(err), '0);
        send(2'd1, rnd());
        check("t8_err_first", OUT_W'(err), '0);
        send(2'd1, rnd());
        check("t8_err_dup", OUT_W'(err), OUT_W'(1));
        send(2'd2, rnd());
        consume();
        check("t8_err_sticky", OUT_W'(err), OUT_W'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t8_err_flushed", OUT_W'(err), '0);
        send(2'd3, rnd());
        check("t8_err_oor", OUT_W'(err), OUT_W'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/overlap_accum_seq.md
OVERLAP_ACCUM_SEQ -- requirements
Module: overlap_accum_seq

Interface
REQ-001 SHALL provide parameter SEG_W, default 33: shift step between partial-product positions (bits).
REQ-002 SHALL provide parameter NSEG, default 3: number of partial products per frame, NSEG >= 2.
REQ-003 SHALL derive localparams PP_W = 2*SEG_W-1, OUT_W = (NSEG-1)*SEG_W + PP_W (131 at defaults), IDX_W = max(1, clog2(NSEG)).
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL provide port flush  input  1  synchronous frame abort.
REQ-007 SHALL provide port pp_valid  input  1  partial product offered.
REQ-008 SHALL provide port pp_ready  output  1  partial product accepted when pp_valid & pp_ready.
REQ-009 SHALL provide port pp_idx  input  IDX_W  position index k; the product is placed at bit offset k*SEG_W.
REQ-010 SHALL provide port pp_data  input  PP_W  carry-less partial product.
REQ-011 SHALL provide port res_valid  output  1  result frame available.
REQ-012 SHALL provide port res_ready  input  1  result consumed when res_valid & res_ready.
REQ-013 SHALL provide port res_data  output  OUT_W  overlapped GF(2) sum.

Function
REQ-014 SHALL implement states ACC (collecting) and DONE (result held); no other states.
REQ-015 On accept in ACC, SHALL update acc <= acc XOR (pp_data << pp_idx*SEG_W), truncated to OUT_W, and increment cnt.
REQ-016 SHALL accept products in any index order; duplicate indices are XORed in again (GF(2) semantics) and counted.
REQ-017 Indices >= NSEG SHALL be accepted, leave acc unchanged, and not increment cnt.
REQ-018 When the accept brings cnt to NSEG, SHALL enter DONE next cycle with res_valid=1 and res_data = final acc (latency 1 cycle after last accept).
REQ-019 pp_ready SHALL be 1 in ACC; in DONE, pp_ready SHALL equal res_ready (combinational bypass).
REQ-020 In DONE, res_data and res_valid SHALL remain stable until res_ready=1.
REQ-021 In DONE with res_ready=1 and no accept, SHALL return to ACC with acc=0, cnt=0.
REQ-022 In DONE with res_ready=1 and a simultaneous accept, SHALL return to ACC with acc = shifted new product and cnt=1 (or cnt=0 if index out of range); no bubble.
REQ-023 With NSEG=1 frame completion semantics are undefined; parameter checking SHALL reject NSEG<2 at elaboration.
REQ-024 flush=1 SHALL force ACC, acc=0, cnt=0, res_valid=0 next cycle, overriding any accept or result handshake in that cycle; pp_ready SHALL be 0 while flush=1.
REQ-025 res_data SHALL equal acc at all times; outputs are registered except pp_ready.

Reset
REQ-026 rst_n=0 SHALL asynchronously set state=ACC, acc=0, cnt=0, res_valid=0, res_data=0, err=0 (if present).
REQ-027 pp_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-028 Reset mid-frame SHALL discard all partial sums; no product accepted before reset contributes afterwards.

Configuration
REQ-029 Macro OVERLAP_ACCUM_DUPCHK_EN, when defined, SHALL add output err (1 bit) and a NSEG-bit seen-mask cleared at frame start.
REQ-030 With the macro, accepting an index already in the mask or >= NSEG SHALL set err=1, sticky until flush or reset; data path unchanged.
REQ-031 Without the macro, port err and the mask SHALL not exist; behaviour otherwise identical.

Verification
REQ-032 Defaults; accept idx0=1, idx1=1, idx2=1 on consecutive cycles -> res_valid next cycle, res_data bits 0, 33, 66 set, all others 0.
REQ-033 Defaults; idx0 = 65'h1_FFFF_FFFF_FFFF_FFFF, idx1 = same, idx2 = 0 -> res_data bits 0..32 = 1, bits 33..64 = 0, bits 65..97 = 1, bits 98..130 = 0.
REQ-034 Order 2,0,1 vs 0,1,2 with random data -> identical res_data; golden = XOR of shifted products.
REQ-035 Hold res_ready=0 for 5 cycles in DONE while pp_valid=1 -> pp_ready=0, res_data stable; then res_ready=1 with idx0=5 -> next frame acc=5, cnt=1.
REQ-036 Flush after 2 accepts, then 3 fresh products -> result contains only the fresh products; with OVERLAP_ACCUM_DUPCHK_EN, idx1 twice -> err=1 until flush.
REQ-037 rst_n low asynchronously mid-frame (between edges) -> outputs 0 immediately; subsequent full frame correct.
